x_top_bus: RTL and testbench

X_TOP_BUS -- requirements
Module: x_top_bus

---
 rtl/x_bus_pkg.sv | 8 +
 rtl/x_top_bus_timer.sv | 20 ++
 rtl/x_top_bus.sv | 100 ++++++++++
 tb/tb_x_top_bus.sv | 114 +++++++++++
 4 files changed

// File: rtl/x_bus_pkg.sv
// x_bus_pkg: shared FSM state type, default error data and saturating counter helper for x_top_bus
package x_bus_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/x_top_bus_timer.sv
// x_top_bus_timer: stall counter; clear wins over enable, expire flags the last allowed cycle
// Ports: i_clk/i_nrst clock and async active-low reset; clear zeroes the count;
//        enable counts one per cycle; expire is high while count == p_timeout-1.
module x_top_bus_timer #(
    parameter int p_timeout = 100000
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(p_timeout);
    logic [W-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_nrst)
        if (!i_nrst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    assign expire = (cnt == W'(p_timeout - 1));
endmodule

// File: rtl/x_top_bus.sv
// x_top_bus: single-master to p_slaves bus decoder with stall timeout and error responses
// Ports: i_clk/i_nrst clock and async active-low reset;
//        i_valid/i_rnw/i_addr/i_data master request, o_accept/o_data/o_err one-cycle response;
//        o_slv_valid one-hot slave strobe, o_slv_rnw/o_slv_addr/o_slv_data broadcast request;
//        i_slv_accept/i_slv_data per-slave accept and read data; o_err_cnt saturating error count.
module x_top_bus
    import x_bus_pkg::*;
#(
    parameter int p_slaves = 4,
    parameter int p_data_w = 32,
    parameter int p_addr_w = 32,
    parameter int p_timeout = 100000,
    parameter logic [p_data_w-1:0] p_err_data = p_data_w'(ERR_DATA_DEFAULT)
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_valid,
    input  logic                         i_rnw,
    input  logic [p_addr_w-1:0]          i_addr,
    input  logic [p_data_w-1:0]          i_data,
    output logic                         o_accept,
    output logic [p_data_w-1:0]          o_data,
    output logic                         o_err,
    output logic [p_slaves-1:0]          o_slv_valid,
    output logic                         o_slv_rnw,
    output logic [p_addr_w-1:0]          o_slv_addr,
    output logic [p_data_w-1:0]          o_slv_data,
    input  logic [p_slaves-1:0]          i_slv_accept,
    input  logic [p_slaves*p_data_w-1:0] i_slv_data,
    output logic [7:0]                   o_err_cnt
);
    localparam int S = (p_slaves > 1) ? $clog2(p_slaves) : 1;
    state_t state;
    logic [S-1:0] idx;
    logic [S-1:0] sel;
    logic unmapped;
    logic expire;
    assign sel = i_addr[p_addr_w-1 -: S];
    assign unmapped = int'(sel) >= p_slaves;
    x_top_bus_timer #(.p_timeout(p_timeout)) u_timer (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .clear (state != REQ),
        .enable(state == REQ),
        .expire(expire)
    );
    always_ff @(posedge i_clk or negedge i_nrst)
        if (!i_nrst) begin
            state       <= IDLE;
            idx         <= '0;
            o_slv_rnw   <= 1'b0;
            o_slv_addr  <= '0;
            o_slv_data  <= '0;
            o_slv_valid <= '0;
            o_accept    <= 1'b0;
            o_err       <= 1'b0;
            o_data      <= '0;
            o_err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    o_slv_rnw  <= i_rnw;
                    o_slv_addr <= i_addr;
                    o_slv_data <= i_data;
                    idx        <= sel;
                    if (unmapped) begin
                        state     <= RESP;
                        o_accept  <= 1'b1;
                        o_err     <= 1'b1;
                        o_data    <= p_err_data;
                        o_err_cnt <= sat_inc(o_err_cnt);
                    end else begin
                        state       <= REQ;
                        o_slv_valid <= p_slaves'(1) << sel;
                    end
                end
                // accept takes priority over a coincident timeout
                REQ: if (i_slv_accept[idx]) begin
                    state       <= RESP;
                    o_slv_valid <= '0;
                    o_accept    <= 1'b1;
                    o_data      <= o_slv_rnw ? i_slv_data[int'(idx)*p_data_w +: p_data_w] : '0;
                end else if (expire) begin
                    state       <= RESP;
                    o_slv_valid <= '0;
                    o_accept    <= 1'b1;
                    o_err       <= 1'b1;
                    o_data      <= p_err_data;
                    o_err_cnt   <= sat_inc(o_err_cnt);
                end
                RESP: begin
                    state    <= IDLE;
                    o_accept <= 1'b0;
                    o_err    <= 1'b0;
                    o_data   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_x_top_bus.sv
// tb_x_top_bus: scoreboard bench for x_top_bus with 3 slaves and an 8-cycle timeout
module tb_x_top_bus;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        valid = 1'b0, rnw = 1'b0;
    logic [31:0] addr = '0, data = '0;
    logic        accept, err;
    logic [31:0] rdata;
    logic [2:0]  slv_valid;
    logic        slv_rnw;
    logic [31:0] slv_addr, slv_data;
    logic [2:0]  slv_accept = '0;
    logic [95:0] slv_rdata = '0;
    logic [7:0]  err_cnt;
    int          total = 0, passed = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    x_top_bus #(.p_slaves(3), .p_data_w(32), .p_addr_w(32), .p_timeout(8)) u_dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_valid(valid), .i_rnw(rnw), .i_addr(addr), .i_data(data),
        .o_accept(accept), .o_data(rdata), .o_err(err),
        .o_slv_valid(slv_valid), .o_slv_rnw(slv_rnw), .o_slv_addr(slv_addr), .o_slv_data(slv_data),
        .i_slv_accept(slv_accept), .i_slv_data(slv_rdata), .o_err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    // stall: cycles the target slave withholds accept; other slaves accept throughout
    task automatic xfer(input logic r, input logic [31:0] a, input logic [31:0] d, input int stall,
                        input logic [31:0] sd, input logic exp_err, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_vcyc, input logic [2:0] exp_sv);
        int n = 0, vcyc = 0;
        bit done = 0;
        logic [32:0] e;
        sb.push_back({exp_err, exp_data});
        @(posedge clk); #1;
        valid = 1'b1; rnw = r; addr = a; data = d; slv_accept = '0;
        slv_rdata = {3{~sd}};
        if (exp_sv != 0) slv_rdata[int'(a[31:30])*32 +: 32] = sd;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (accept) begin
                e = sb.pop_front();
                check("resp_err", err, e[32]);
                check("resp_data", rdata, e[31:0]);
                check("latency", n, exp_lat);
                check("valid_cycles", vcyc, exp_vcyc);
                check("strobe_off", slv_valid, 3'b000);
                done = 1;
                valid = 1'b0; slv_accept = '0;
            end else if (slv_valid != 0) begin
                vcyc++;
                check("slv_valid", slv_valid, exp_sv);
                check("slv_fields", {slv_rnw, slv_addr, slv_data}, {r, a, d});
                slv_accept = (vcyc == stall + 1) ? exp_sv : (~exp_sv & 3'b111);
            end
        end
        if (!done) begin
            check("resp_timeout", n, exp_lat);
            valid = 1'b0; slv_accept = '0;
            sb.delete();
        end
        @(posedge clk); #1;
        check("one_cycle_accept", {accept, err, rdata}, 34'd0);
    endtask

    initial begin
        #12;
        check("reset_outputs", {accept, err, rdata, slv_valid, err_cnt}, 45'd0);
        nrst = 1'b1;
        xfer(1'b1, 32'h8000_0010, 32'h0, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 2, 1, 3'b100);
        xfer(1'b0, 32'h4000_0020, 32'hCAFE_F00D, 5, 32'h5555_AAAA, 1'b0, 32'h0, 7, 6, 3'b010);
        xfer(1'b1, 32'h0000_0004, 32'h0, 2, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 4, 3, 3'b001);
        xfer(1'b1, 32'hC000_0000, 32'h0, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1, 0, 3'b000);
        check("err_cnt_unmapped", err_cnt, 8'd1);
        xfer(1'b1, 32'h8000_0000, 32'h0, 100, 32'h1111_2222, 1'b1, 32'hDEAD_BEEF, 9, 8, 3'b100);
        check("err_cnt_timeout", err_cnt, 8'd2);
        xfer(1'b1, 32'h8000_0000, 32'h0, 7, 32'h7777_8888, 1'b0, 32'h7777_8888, 9, 8, 3'b100);
        check("err_cnt_late_accept", err_cnt, 8'd2);
        // reset pulse while a request is stalled at a slave
        @(posedge clk); #1;
        valid = 1'b1; rnw = 1'b1; addr = 32'h4000_0000; slv_accept = '0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_req_strobe", slv_valid, 3'b010);
        valid = 1'b0;
        nrst = 1'b0;
        #1;
        check("reset_mid_req", {accept, err, rdata, slv_valid, slv_rnw, slv_addr, slv_data, err_cnt}, 110'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        check("reset_hold_idle", {accept, slv_valid}, 4'd0);
        xfer(1'b1, 32'h4000_0008, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 3, 2, 3'b010);
        for (int i = 1; i <= 300; i++) begin
            xfer(1'b0, 32'hC000_0100, 32'h0, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1, 0, 3'b000);
            if (i == 254 || i == 255 || i == 300) check("err_cnt_sat", err_cnt, (i > 255) ? 8'd255 : 8'(i));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
